// File: rtl/mdio_pkg.sv
// Shared constants and types for the MDIO Clause 22 management master.
package mdio_pkg;

  localparam logic [1:0] OP_WRITE = 2'b01;
  localparam logic [1:0] OP_READ  = 2'b10;

  // 32-bit frame; reads drive ST/OP/PHYAD/REGAD only, data arrives in bits 16..31
  localparam int FRAME_BITS      = 32;
  localparam int READ_DRIVE_BITS = 14;
  localparam int RD_DATA_START   = 16;

  typedef enum logic {
    IDLE = 1'b0,
    XFER = 1'b1
  } state_t;

endpackage

// File: rtl/mdio_clkgen.sv
// MDC generator: clk/2 toggle plus strobes flagging the edge about to happen.
module mdio_clkgen (
  input  logic clk,
  input  logic rst,
  output logic mdc_o,
  output logic fall_o,
  output logic rise_o
);

  logic mdc_q;

  // Free-running divide-by-two, parked low in reset
  always_ff @(posedge clk) begin
    if (rst) mdc_q <= 1'b0;
    else     mdc_q <= ~mdc_q;
  end

  // fall_o: MDC goes 1->0 on the coming clk edge; rise_o: it goes 0->1
  assign mdc_o  = mdc_q;
  assign fall_o = mdc_q;
  assign rise_o = ~mdc_q;

endmodule

// File: rtl/mdio_generador.sv
// MDIO management master: serializes a 32-bit frame on MDC falling edges,
// releases the pad for the read turnaround/data and captures 16 read bits.
module mdio_generador
  import mdio_pkg::*;
(
  input  logic        clk,
  input  logic        rst,
  input  logic        MDIO_START,
  input  logic [31:0] T_DATA,
  input  logic        MDIO_IN,
  output logic [15:0] RD_DATA,
  output logic        DATA_RDY,
  output logic        MDC,
  output logic        MDIO_OE,
  output logic        MDIO_OUT
);

  logic fall, rise;

  mdio_clkgen u_clkgen (
    .clk    (clk),
    .rst    (rst),
    .mdc_o  (MDC),
    .fall_o (fall),
    .rise_o (rise)
  );

  state_t      state_q, state_d;
  logic [31:0] sh_q, sh_d;
  // cnt = number of bits already put on the wire; 32 means bit 31 is on the wire
  logic [5:0]  cnt_q, cnt_d;
  logic        is_rd_q, is_rd_d;
  logic [15:0] cap_q, cap_d;
  logic [15:0] rd_q, rd_d;
  logic        oe_q, oe_d;
  logic        out_q, out_d;
  logic        rdy_q, rdy_d;
  logic        drv;

  // State and datapath registers
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      sh_q    <= '0;
      cnt_q   <= '0;
      is_rd_q <= 1'b0;
      cap_q   <= '0;
      rd_q    <= '0;
      oe_q    <= 1'b0;
      out_q   <= 1'b0;
      rdy_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      sh_q    <= sh_d;
      cnt_q   <= cnt_d;
      is_rd_q <= is_rd_d;
      cap_q   <= cap_d;
      rd_q    <= rd_d;
      oe_q    <= oe_d;
      out_q   <= out_d;
      rdy_q   <= rdy_d;
    end
  end

  // Frame sequencing: launch bits on MDC fall, sample read data on MDC rise
  always_comb begin
    state_d = state_q;
    sh_d    = sh_q;
    cnt_d   = cnt_q;
    is_rd_d = is_rd_q;
    cap_d   = cap_q;
    rd_d    = rd_q;
    oe_d    = oe_q;
    out_d   = out_q;
    rdy_d   = 1'b0;
    drv     = 1'b0;
    unique case (state_q)
      IDLE: begin
        oe_d  = 1'b0;
        out_d = 1'b0;
        if (MDIO_START) begin
          sh_d    = T_DATA;
          cnt_d   = '0;
          is_rd_d = (T_DATA[29:28] == OP_READ);
          cap_d   = '0;
          state_d = XFER;
        end
      end
      XFER: begin
        if (fall) begin
          if (cnt_q == 6'(FRAME_BITS)) begin
            // fall edge closing bit 31
            state_d = IDLE;
            oe_d    = 1'b0;
            out_d   = 1'b0;
            if (is_rd_q) begin
              rd_d  = cap_q;
              rdy_d = 1'b1;
            end
          end else begin
            drv   = !is_rd_q || (cnt_q < 6'(READ_DRIVE_BITS));
            oe_d  = drv;
            out_d = drv & sh_q[31];
            sh_d  = {sh_q[30:0], 1'b0};
            cnt_d = cnt_q + 6'd1;
          end
        end else if (rise && is_rd_q && (cnt_q > 6'(RD_DATA_START))) begin
          // mid-bit sample for bits 16..31
          cap_d = {cap_q[14:0], MDIO_IN};
        end
      end
      default: state_d = IDLE;
    endcase
  end

  assign RD_DATA  = rd_q;
  assign DATA_RDY = rdy_q;
  assign MDIO_OE  = oe_q;
  assign MDIO_OUT = out_q;

endmodule

// File: tb/tb_mdio_generador.sv
// Self-checking bench for mdio_generador: directed plus random frames against
// a frame-level model (expected bit stream, drive window, read result).
module tb_mdio_generador;

  logic        clk = 1'b0;
  logic        rst;
  logic        MDIO_START;
  logic [31:0] T_DATA;
  logic        MDIO_IN;
  logic [15:0] RD_DATA;
  logic        DATA_RDY;
  logic        MDC;
  logic        MDIO_OE;
  logic        MDIO_OUT;

  int passed = 0;
  int total  = 0;
  logic [15:0] rd_model = 16'h0000;

  mdio_generador dut (
    .clk        (clk),
    .rst        (rst),
    .MDIO_START (MDIO_START),
    .T_DATA     (T_DATA),
    .MDIO_IN    (MDIO_IN),
    .RD_DATA    (RD_DATA),
    .DATA_RDY   (DATA_RDY),
    .MDC        (MDC),
    .MDIO_OE    (MDIO_OE),
    .MDIO_OUT   (MDIO_OUT)
  );

  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("FAIL watchdog timeout");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) passed++;
    else begin
      $display("FAIL %s got=%0h want=%0h", tag, obs, exp);
      $error("%s got %0h want %0h", tag, obs, exp);
    end
  endtask

  // One frame. busy_bit/abort_bit < 0 disable those hooks.
  task automatic frame(input logic [31:0] td, input logic [15:0] rv,
                       input int busy_bit, input int abort_bit, input string tg);
    logic rd;
    logic found;
    logic ob, eoe;
    rd    = (td[29:28] == 2'b10);
    found = 1'b0;
    T_DATA = td;
    MDIO_START = 1'b1;
    @(negedge clk);
    MDIO_START = 1'b0;
    T_DATA = $urandom;
    chk({tg, ".lat"}, 32'(MDIO_OE), 32'd0);
    for (int k = 0; k < 3 && !found; k++) begin
      @(negedge clk);
      found = MDIO_OE;
    end
    chk({tg, ".start"}, 32'(found), 32'd1);
    if (!found) return;
    for (int n = 0; n < 32; n++) begin
      ob  = td[31-n];
      eoe = !rd || (n < 14);
      chk($sformatf("%s.mdc0_%0d", tg, n), 32'(MDC), 32'd0);
      chk($sformatf("%s.oe%0d", tg, n), 32'(MDIO_OE), 32'(eoe));
      if (eoe) chk($sformatf("%s.out%0d", tg, n), 32'(MDIO_OUT), 32'(ob));
      chk($sformatf("%s.rdy%0d", tg, n), 32'(DATA_RDY), 32'd0);
      MDIO_IN = (rd && n >= 16) ? rv[31-n] : 1'($urandom);
      T_DATA  = $urandom;
      if (n == abort_bit) begin
        rst = 1'b1;
        @(negedge clk);
        chk({tg, ".ab_mdc"}, 32'(MDC), 32'd0);
        chk({tg, ".ab_oe"}, 32'(MDIO_OE), 32'd0);
        chk({tg, ".ab_out"}, 32'(MDIO_OUT), 32'd0);
        chk({tg, ".ab_rdy"}, 32'(DATA_RDY), 32'd0);
        chk({tg, ".ab_rd"}, 32'(RD_DATA), 32'h0);
        rst = 1'b0;
        rd_model = 16'h0000;
        return;
      end
      if (n == busy_bit) begin
        MDIO_START = 1'b1;
        T_DATA = ~td;
      end
      @(negedge clk);
      MDIO_START = 1'b0;
      chk($sformatf("%s.mdc1_%0d", tg, n), 32'(MDC), 32'd1);
      chk($sformatf("%s.oeh%0d", tg, n), 32'(MDIO_OE), 32'(eoe));
      if (eoe) chk($sformatf("%s.outh%0d", tg, n), 32'(MDIO_OUT), 32'(ob));
      @(negedge clk);
    end
    chk({tg, ".end_oe"}, 32'(MDIO_OE), 32'd0);
    chk({tg, ".end_out"}, 32'(MDIO_OUT), 32'd0);
    chk({tg, ".end_rdy"}, 32'(DATA_RDY), 32'(rd));
    if (rd) rd_model = rv;
    chk({tg, ".end_rd"}, 32'(RD_DATA), 32'(rd_model));
    @(negedge clk);
    chk({tg, ".post_rdy"}, 32'(DATA_RDY), 32'd0);
    chk({tg, ".post_rd"}, 32'(RD_DATA), 32'(rd_model));
  endtask

  initial begin
    logic [31:0] td;
    logic        any_oe;
    rst = 1'b1;
    MDIO_START = 1'b0;
    T_DATA = 32'h0;
    MDIO_IN = 1'b0;

    // reset: 4 clk, all outputs at reset values
    repeat (4) @(negedge clk);
    chk("rst.mdc", 32'(MDC), 32'd0);
    chk("rst.oe", 32'(MDIO_OE), 32'd0);
    chk("rst.out", 32'(MDIO_OUT), 32'd0);
    chk("rst.rd", 32'(RD_DATA), 32'h0);
    chk("rst.rdy", 32'(DATA_RDY), 32'd0);
    rst = 1'b0;
    @(negedge clk); chk("rst.tog1", 32'(MDC), 32'd1);
    @(negedge clk); chk("rst.tog2", 32'(MDC), 32'd0);
    @(negedge clk); chk("rst.tog3", 32'(MDC), 32'd1);
    chk("rst.idle_oe", 32'(MDIO_OE), 32'd0);

    // write frame
    frame(32'h5A3C_1234, 16'h0, -1, -1, "wr");
    // read frame returning 0xBEEF
    frame(32'h6B5A_0000, 16'hBEEF, -1, -1, "rd");

    // busy start during a write: ignored, nothing queued
    frame(32'h5A3C_1234, 16'h0, 10, -1, "busy");
    any_oe = 1'b0;
    for (int k = 0; k < 8; k++) begin
      @(negedge clk);
      any_oe |= MDIO_OE;
    end
    chk("busy.noframe", 32'(any_oe), 32'd0);
    chk("busy.rd_hold", 32'(RD_DATA), 32'hBEEF);

    // reset at bit 20 of a read
    frame(32'h6B5A_0000, 16'h5555, -1, 20, "abort");
    repeat (3) @(negedge clk);
    chk("abort.rd_zero", 32'(RD_DATA), 32'h0);

    // back-to-back reads
    frame(32'h6B5A_0000, 16'h1234, -1, -1, "b2b1");
    frame(32'h6B5A_0000, 16'hA5A5, -1, -1, "b2b2");

    // random frames, OP mix of write, read and other codes
    for (int i = 0; i < 8; i++) begin
      td = $urandom;
      td[31:30] = 2'b01;
      case ($urandom_range(0, 2))
        0: td[29:28] = 2'b01;
        1: td[29:28] = 2'b10;
        default: td[29:28] = 2'($urandom);
      endcase
      frame(td, 16'($urandom), -1, -1, $sformatf("rnd%0d", i));
    end

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
